mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide responder that owns the HI/LO register pair for the MIPS core.
- The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it and reads HI/LO for MFHI/MFLO.
- Uses a Start/Busy/Done handshake so the core can stall on MFHI/MFLO or a new issue while an operation runs.
- Radix-2 shift-add multiply and restoring divide with a final sign-fix cycle.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits.
CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
Start  input  1  issue request; sampled at a rising edge
Func  input  6  MIPS R-form funct: MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MTHI 6'h11, MTLO 6'h13
Rdata1  input  XLEN  rs: multiplicand/dividend, or MTHI/MTLO source
Rdata2  input  XLEN  rt: multiplier/divisor
HI  output  XLEN  HI register (product high word / remainder)
LO  output  XLEN  LO register (product low word / quotient)
Busy  output  1  operation in flight; Start is ignored while high
Done  output  1  one-cycle pulse when HI/LO hold a new mult/div result

Behaviour:
- Reset (RST low, asynchronous, also mid-operation):
  - HI=0, LO=0, Busy=0, Done=0, state IDLE, counter 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE with Start=1 at edge E0:
  - MULT/MULTU/DIV/DIVU:
    - latch the operands (magnitudes for signed ops) and the result signs; counter=XLEN; go to RUN; Busy=1 after E0.
  - MTHI: HI<=Rdata1 at E0. MTLO: LO<=Rdata1 at E0. Stay in IDLE; no Busy, no Done.
  - Any other Func: ignored.
- RUN: one iteration per edge, edges E1..E32; counter decrements; go to FIX when the counter reaches 0.
  - Multiply: 2*XLEN accumulator; add the multiplicand when the multiplier LSB is 1; shift right.
  - Divide: restoring shift/subtract on the magnitudes.
- FIX at E33:
  - Apply signs and write HI/LO.
  - Busy drops to 0 and Done=1 for exactly one cycle after E33.
  - Return to IDLE.
  - Result latency is therefore 33 edges from acceptance.
- HI/LO hold their old values throughout RUN and change only at FIX.
- Start while Busy=1: ignored, including MTHI/MTLO; the core must stall.
- Start in the Done cycle: accepted normally (back-to-back issue allowed).
- Signed multiply: the 64-bit product is negated when the operand signs differ.
- Signed divide:
  - quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (DIV and DIVU): LO=0xFFFFFFFF, HI=Rdata1 unchanged; same 33-edge latency.
- Unsigned ops use the raw operands with no sign fix.

Optional Feature:
- Macro: MDU_EARLY_EXIT_EN.
- Defined:
  - Multiply leaves RUN as soon as the remaining multiplier bits are all zero.
  - Iteration count = bit index of the MS one of |rt| plus 1, minimum 1; then FIX as normal.
  - Example: rt=3 gives 2 iterations, and Done follows E3.
  - Divide is unaffected.
- Undefined: every mult/div takes exactly 32 iterations plus FIX.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after E33: HI=0xFFFFFFFE, LO=0x00000001, Done pulses once, Busy high E0..E33.
- MULT 0xFFFFFFFD(-3)*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 -> HI=0x00000007, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 issued while Busy -> HI unchanged; after Done, MTLO 0xCAFEBABE -> LO=0xCAFEBABE next edge, no Done.
- DIVU 100/7 started, RST pulsed low at E10 -> HI=LO=0, Busy=0 immediately; no Done; new MULTU 6*7 -> LO=42, HI=0.
- With MDU_EARLY_EXIT_EN, MULTU 5*3 -> LO=15 with Done after E3; without the macro, Done after E33.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [5:0]      Func;
  logic [XLEN-1:0] Rdata1;
  logic [XLEN-1:0] Rdata2;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic            Busy;
  logic            Done;

  modport master (output Start, Func, Rdata1, Rdata2, input HI, LO, Busy, Done);
  modport slave  (input Start, Func, Rdata1, Rdata2, output HI, LO, Busy, Done);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiply, restoring divide, sign-fix cycle.
// Optional macro MDU_EARLY_EXIT_EN: multiply stops iterating once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic CLK,
  input  logic RST,
  mdu_if.slave bus
);
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;     // {remainder/product high, quotient/multiplier low}
  logic [XLEN-1:0]     opnd_reg;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]     rs_reg;
  logic                is_div_reg, neg_q_reg, neg_r_reg, dbz_reg;
  logic [XLEN-1:0]     hi_reg, lo_reg;
  logic                done_reg;
  logic                busy;
`ifdef MDU_EARLY_EXIT_EN
  logic [XLEN-1:0]     mplier_reg;
`endif

  // Issue decode
  logic            accept, is_mul_op, is_div_op, is_signed, op_start;
  logic [XLEN-1:0] abs_a, abs_b;

  assign accept    = (state_reg == IDLE) && bus.Start;
  assign is_mul_op = (bus.Func == F_MULT) || (bus.Func == F_MULTU);
  assign is_div_op = (bus.Func == F_DIV)  || (bus.Func == F_DIVU);
  assign is_signed = (bus.Func == F_MULT) || (bus.Func == F_DIV);
  assign op_start  = accept && (is_mul_op || is_div_op);
  assign abs_a     = (is_signed && bus.Rdata1[XLEN-1]) ? -bus.Rdata1 : bus.Rdata1;
  assign abs_b     = (is_signed && bus.Rdata2[XLEN-1]) ? -bus.Rdata2 : bus.Rdata2;

  // One multiply step: conditional add into the high half, then shift right with carry.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // One restoring divide step on the shifted partial remainder.
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] div_next;
  assign rem_sh   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, opnd_reg};
  assign ge       = ~diff[XLEN+1];
  assign div_next = ge ? {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1}
                       : {rem_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};

  logic last_iter;
`ifdef MDU_EARLY_EXIT_EN
  assign last_iter = (cnt_reg == CNT_W'(1)) || (!is_div_reg && ((mplier_reg >> 1) == '0));
`else
  assign last_iter = (cnt_reg == CNT_W'(1));
`endif

  // Final sign fix; an early-exited product still sits cnt_reg bits too high.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_hi, fix_lo;
`ifdef MDU_EARLY_EXIT_EN
  assign prod = acc_reg >> cnt_reg;
`else
  assign prod = acc_reg;
`endif
  assign prod_s = neg_q_reg ? -prod : prod;
  assign quo_s  = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_s  = neg_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  always_comb begin
    fix_hi = prod_s[2*XLEN-1:XLEN];
    fix_lo = prod_s[XLEN-1:0];
    if (is_div_reg) begin
      if (dbz_reg) begin
        fix_hi = rs_reg;
        fix_lo = '1;
      end else begin
        fix_hi = rem_s;
        fix_lo = quo_s;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (op_start)  state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      rs_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dbz_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
`ifdef MDU_EARLY_EXIT_EN
      mplier_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.Func == F_MTHI) hi_reg <= bus.Rdata1;
            if (bus.Func == F_MTLO) lo_reg <= bus.Rdata1;
            if (op_start) begin
              cnt_reg    <= CNT_W'(XLEN);
              acc_reg    <= {{XLEN{1'b0}}, (is_mul_op ? abs_b : abs_a)};
              opnd_reg   <= is_mul_op ? abs_a : abs_b;
              rs_reg     <= bus.Rdata1;
              is_div_reg <= is_div_op;
              neg_q_reg  <= is_signed && (bus.Rdata1[XLEN-1] ^ bus.Rdata2[XLEN-1]);
              neg_r_reg  <= is_signed && bus.Rdata1[XLEN-1];
              dbz_reg    <= (bus.Rdata2 == '0);
`ifdef MDU_EARLY_EXIT_EN
              mplier_reg <= abs_b;
`endif
            end
          end
        end
        RUN: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
`ifdef MDU_EARLY_EXIT_EN
          mplier_reg <= mplier_reg >> 1;
`endif
        end
        FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;
  assign bus.Busy = busy;
  assign bus.Done = done_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven checks of mult_div_unit results, latency, handshake and reset behaviour.
module tb_mult_div_unit;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mdu_if #(.XLEN(32)) bus ();

  mult_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected issue-to-Done edge count.
  function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MDU_EARLY_EXIT_EN
    if (f == F_MULT || f == F_MULTU) begin
      logic [31:0] m;
      int msb;
      m   = (f == F_MULT && b[31]) ? -b : b;
      msb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      lat = msb + 2;
    end
`endif
    return lat;
  endfunction

  // Issues one op, follows it to Done, checks Busy/hold behaviour and latency.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi0, lo0;
    bit          hold_ok;
    int          lat;
    @(negedge clk);
    bus.Start = 1'b1; bus.Func = f; bus.Rdata1 = a; bus.Rdata2 = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    check({name, "_busy_e0"}, 32'(bus.Busy), 32'd1);
    hi0 = bus.HI; lo0 = bus.LO; hold_ok = 1'b1; lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.Done) begin
        lat = n;
        break;
      end
      if (bus.HI !== hi0 || bus.LO !== lo0 || bus.Busy !== 1'b1) hold_ok = 1'b0;
    end
    check({name, "_hold"}, 32'(hold_ok), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat(f, b)));
    check({name, "_busy_done"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0;
    bus.Start = 1'b0; bus.Func = '0; bus.Rdata1 = '0; bus.Rdata2 = '0;

    vecs[0]  = '{"multu_max",    F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_neg3x5",  F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div_neg7by2",  F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7by0",    F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{"div_min_by_m1",F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"multu_5x3",    F_MULTU, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F};
    vecs[6]  = '{"divu_100by7",  F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{"mult_7xneg2",  F_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[8]  = '{"div_7byneg2",  F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{"mult_min_sq",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{"div_neg7by0",  F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi",   bus.HI,          32'h0);
    check("rst_lo",   bus.LO,          32'h0);
    check("rst_busy", 32'(bus.Busy),   32'd0);
    check("rst_done", 32'(bus.Done),   32'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].name, vecs[i].func, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_hi"}, bus.HI, vecs[i].hi);
      check({vecs[i].name, "_lo"}, bus.LO, vecs[i].lo);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, 32'(bus.Done), 32'd0);
      $display("[TB] %s func=%h a=%h b=%h -> HI=%h LO=%h", vecs[i].name, vecs[i].func,
               vecs[i].a, vecs[i].b, bus.HI, bus.LO);
    end

    // MTHI while busy is dropped; MTLO after Done lands next edge without Done.
    begin
      logic [31:0] hi_before;
      bit          done_seen;
      hi_before = bus.HI;
      @(negedge clk);
      bus.Start = 1'b1; bus.Func = F_DIVU; bus.Rdata1 = 32'd100; bus.Rdata2 = 32'd7;
      @(negedge clk);
      bus.Func = F_MTHI; bus.Rdata1 = 32'h12345678;
      @(posedge clk); #1;
      bus.Start = 1'b0;
      check("mthi_busy_hi", bus.HI, hi_before);
      done_seen = 1'b0;
      for (int n = 0; n < 100 && !done_seen; n++) begin
        @(posedge clk); #1;
        if (bus.Done) done_seen = 1'b1;
      end
      check("mthi_busy_done", 32'(done_seen), 32'd1);
      check("mthi_busy_hi_after", bus.HI, 32'd2);
      @(negedge clk);
      bus.Start = 1'b1; bus.Func = F_MTLO; bus.Rdata1 = 32'hCAFEBABE;
      @(posedge clk); #1;
      bus.Start = 1'b0;
      check("mtlo_lo",   bus.LO,        32'hCAFEBABE);
      check("mtlo_done", 32'(bus.Done), 32'd0);
      check("mtlo_busy", 32'(bus.Busy), 32'd0);
      $display("[TB] mthi_busy/mtlo HI=%h LO=%h", bus.HI, bus.LO);
    end

    // Asynchronous reset in the middle of a divide.
    begin
      bit done_seen;
      @(negedge clk);
      bus.Start = 1'b1; bus.Func = F_DIVU; bus.Rdata1 = 32'd100; bus.Rdata2 = 32'd7;
      @(posedge clk); #1;
      bus.Start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_hi",   bus.HI,        32'h0);
      check("midrst_lo",   bus.LO,        32'h0);
      check("midrst_busy", 32'(bus.Busy), 32'd0);
      check("midrst_done", 32'(bus.Done), 32'd0);
      @(negedge clk); rst = 1'b1;
      done_seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (bus.Done) done_seen = 1'b1;
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);
      run_op("multu_6x7", F_MULTU, 32'd6, 32'd7);
      check("multu_6x7_hi", bus.HI, 32'd0);
      check("multu_6x7_lo", bus.LO, 32'd42);
      $display("[TB] midrst then multu_6x7 -> HI=%h LO=%h", bus.HI, bus.LO);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
